byte_fetch_bridge: RTL

- Responder for the core's wide fetch interface (addr, extra, data, error), backed by a byte-wide, single-port synchronous memory.
- Gathers 1..2**EXTRA bytes, one per cycle, into a little-endian window, then signals completion with a one-cycle ack.
- Bounds-checks each request against a programmable window.
- Lets the core fetch from RAM-like or external storage that cannot return a full window in one cycle.

---
 rtl/byte_fetch_bridge.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/byte_fetch_bridge.sv
// Purpose : fetch bridge; gathers extra+1 bytes, one per cycle, from a byte-wide
//           synchronous memory into a little-endian window and completes with a one-cycle ack.
// Latency : accepted request -> ack in cycle N+2 (N = extra+1); bounds violation -> ack in cycle 1.
// Backpr. : no ready signal. i_req is sampled only in IDLE/DONE and ignored while o_busy is high.
//
// Ports:
//   i_clk, i_reset          clock, asynchronous active-high reset
//   i_req                   request strobe
//   i_addr, i_extra         byte address of lane 0, number of bytes beyond the first
//   i_lower_bound,
//   i_upper_bound           inclusive legal address window, sampled at acceptance
//   o_data, o_error, o_ack  result window, bounds-violation flag, completion pulse
//   o_busy                  high while the request is in READ/FILL
//   o_bmem_addr, o_bmem_rd  backing-memory read request (address forced to 0 when idle)
//   i_bmem_rdata            backing-memory read data, valid the cycle after o_bmem_rd
module byte_fetch_bridge #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_req,
    input  logic [AW:0]              i_addr,
    input  logic [EXTRA-1:0]         i_extra,
    input  logic [AW:0]              i_lower_bound,
    input  logic [AW:0]              i_upper_bound,
    output logic [(2**EXTRA)*DW-1:0] o_data,
    output logic                     o_error,
    output logic                     o_ack,
    output logic                     o_busy,
    output logic [AW:0]              o_bmem_addr,
    output logic                     o_bmem_rd,
    input  logic [DW-1:0]            i_bmem_rdata
);

    localparam int LANES = 2**EXTRA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_FILL = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [AW:0]            r_base;       // address of lane 0, latched at acceptance
    logic [EXTRA-1:0]       r_last;       // index of the last lane to read
    logic [EXTRA-1:0]       r_rd_lane;    // lane whose read is on the bus this cycle
    logic [EXTRA-1:0]       r_cap_lane;   // lane whose read data arrives this cycle
    logic                   r_cap_vld;    // i_bmem_rdata carries a requested byte this cycle
    logic [LANES*DW-1:0]    r_data;
    logic                   r_error;
    logic                   r_ack;
    logic                   r_busy;
    logic                   r_bmem_rd;
    logic [AW:0]            r_bmem_addr;

    logic                   w_accept;
    logic                   w_viol;
    logic [AW+1:0]          w_end;
    logic [EXTRA-1:0]       w_next_lane;
    logic [AW:0]            w_next_addr;

    // The end address is one bit wider than an address so that a window running
    // off the top of the address space is caught as a violation instead of wrapping.
    assign w_end       = (AW+2)'(i_addr) + (AW+2)'(i_extra);
    assign w_viol      = (i_addr < i_lower_bound) || (w_end > (AW+2)'(i_upper_bound));
    assign w_accept    = i_req && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Only used while another lane remains, so the increment never overflows and
    // the address cannot pass the already-checked upper bound.
    assign w_next_lane = r_rd_lane + 1'b1;
    assign w_next_addr = r_base + (AW+1)'(w_next_lane);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_last      <= '0;
            r_rd_lane   <= '0;
            r_cap_lane  <= '0;
            r_cap_vld   <= 1'b0;
            r_data      <= '0;
            r_error     <= 1'b0;
            r_ack       <= 1'b0;
            r_busy      <= 1'b0;
            r_bmem_rd   <= 1'b0;
            r_bmem_addr <= '0;
        end else begin
            // Read data trails the strobe by one cycle; track which lane it belongs to.
            r_cap_vld  <= r_bmem_rd;
            r_cap_lane <= r_rd_lane;
            if (r_cap_vld) begin
                r_data[r_cap_lane*DW +: DW] <= i_bmem_rdata;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    r_ack <= 1'b0;
                    if (w_accept) begin
                        r_data    <= '0;
                        r_base    <= i_addr;
                        r_last    <= i_extra;
                        r_rd_lane <= '0;
                        if (w_viol) begin
                            // Rejected request: complete at once, memory untouched.
                            r_state <= S_DONE;
                            r_error <= 1'b1;
                            r_ack   <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state     <= S_READ;
                            r_error     <= 1'b0;
                            r_busy      <= 1'b1;
                            r_bmem_rd   <= 1'b1;
                            r_bmem_addr <= i_addr;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_READ: begin
                    if (r_rd_lane == r_last) begin
                        // Last read is on the bus; its data lands during FILL.
                        r_state     <= S_FILL;
                        r_bmem_rd   <= 1'b0;
                        r_bmem_addr <= '0;
                    end else begin
                        r_rd_lane   <= w_next_lane;
                        r_bmem_addr <= w_next_addr;
                    end
                end

                S_FILL: begin
                    r_state <= S_DONE;
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_data      = r_data;
    assign o_error     = r_error;
    assign o_ack       = r_ack;
    assign o_busy      = r_busy;
    assign o_bmem_rd   = r_bmem_rd;
    assign o_bmem_addr = r_bmem_addr;

endmodule
